// File: rtl/alu.sv
// Single-stage ALU: operand conditioning, AND/ADD, optional result inversion,
// then one register stage holding the result and its zero/negative flags.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    // Handshake: in_valid qualifies x/y/control on a rising edge; out_valid is
    // high for exactly the cycle after each accepted operation. No ready/backpressure.

    logic [WIDTH-1:0] w_xa;
    logic [WIDTH-1:0] w_xb;
    logic [WIDTH-1:0] w_ya;
    logic [WIDTH-1:0] w_yb;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_res;
    logic             w_zr;
    logic             w_ng;

    logic [WIDTH-1:0] r_out;
    logic             r_zr;
    logic             r_ng;
    logic             r_out_valid;

    always_comb begin
        w_xa  = zx ? '0 : x;
        w_xb  = nx ? ~w_xa : w_xa;
        w_ya  = zy ? '0 : y;
        w_yb  = ny ? ~w_ya : w_ya;
        // Sum is truncated to WIDTH bits; the carry-out is intentionally dropped.
        w_r   = f ? (w_xb + w_yb) : (w_xb & w_yb);
        w_res = no ? ~w_r : w_r;
        w_zr  = (w_res == '0);
        w_ng  = w_res[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_zr        <= 1'b1;
            r_ng        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_res;
                r_zr  <= w_zr;
                r_ng  <= w_ng;
            end
        end
    end

    assign out       = r_out;
    assign zr        = r_zr;
    assign ng        = r_ng;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu (WIDTH=4): each check compares {out_valid,out,zr,ng}
// sampled 1 time unit after the rising edge against hand-computed values.
module tb_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] x;
    logic [3:0] y;
    logic       zx, nx, zy, ny, f, no;
    logic       out_valid;
    logic [3:0] out;
    logic       zr;
    logic       ng;

    int n_compared;
    int n_mismatched;

    alu #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .out_valid (out_valid),
        .out       (out),
        .zr        (zr),
        .ng        (ng)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: ctl = {zx,nx,zy,ny,f,no}
    task automatic drive(input logic [3:0] xv, input logic [3:0] yv,
                         input logic [5:0] ctl, input logic v);
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = ctl;
        in_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1010, 4'b0101, 6'b000010, 1'b1);
        #1;
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b0_0000_1_0) begin
            n_mismatched++;
            $display("FAIL reset_initial: got %b want %b", {out_valid, out, zr, ng}, 7'b0_0000_1_0);
        end
        step();
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b0_0000_1_0) begin
            n_mismatched++;
            $display("FAIL reset_ignores_inputs: got %b want %b", {out_valid, out, zr, ng}, 7'b0_0000_1_0);
        end
        drive(4'b0000, 4'b0000, 6'b000000, 1'b0);
        rst = 1'b0;
        step();
    endtask

    task automatic test_and();
        drive(4'b1010, 4'b1100, 6'b000000, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_1000_0_1) begin
            n_mismatched++;
            $display("FAIL and_basic: got %b want %b", {out_valid, out, zr, ng}, 7'b1_1000_0_1);
        end
        // ~0101 & 0011 = 0010
        drive(4'b0101, 4'b0011, 6'b010000, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_0010_0_0) begin
            n_mismatched++;
            $display("FAIL and_nx: got %b want %b", {out_valid, out, zr, ng}, 7'b1_0010_0_0);
        end
    endtask

    task automatic test_add();
        drive(4'b0011, 4'b0101, 6'b000010, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_1000_0_1) begin
            n_mismatched++;
            $display("FAIL add_basic: got %b want %b", {out_valid, out, zr, ng}, 7'b1_1000_0_1);
        end
        drive(4'b1111, 4'b1111, 6'b101010, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_0000_1_0) begin
            n_mismatched++;
            $display("FAIL add_zero: got %b want %b", {out_valid, out, zr, ng}, 7'b1_0000_1_0);
        end
        // 0110+0011=1001, inverted -> 0110
        drive(4'b0110, 4'b0011, 6'b000011, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_0110_0_0) begin
            n_mismatched++;
            $display("FAIL add_no: got %b want %b", {out_valid, out, zr, ng}, 7'b1_0110_0_0);
        end
        // x - y = ~(~x + y): 0110 - 0010 = 0100
        drive(4'b0110, 4'b0010, 6'b010011, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_0100_0_0) begin
            n_mismatched++;
            $display("FAIL add_sub: got %b want %b", {out_valid, out, zr, ng}, 7'b1_0100_0_0);
        end
    endtask

    task automatic test_wrap_const();
        drive(4'b1111, 4'b0001, 6'b000010, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_0000_1_0) begin
            n_mismatched++;
            $display("FAIL wrap: got %b want %b", {out_valid, out, zr, ng}, 7'b1_0000_1_0);
        end
        drive(4'b0101, 4'b1010, 6'b111010, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_1111_0_1) begin
            n_mismatched++;
            $display("FAIL const_minus1: got %b want %b", {out_valid, out, zr, ng}, 7'b1_1111_0_1);
        end
        // all controls set: x,y -> 1111 each, sum 1110, inverted 0001
        drive(4'b0011, 4'b1001, 6'b111111, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_0001_0_0) begin
            n_mismatched++;
            $display("FAIL all_ctl: got %b want %b", {out_valid, out, zr, ng}, 7'b1_0001_0_0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] xs [4];
        logic [3:0] ys [4];
        logic [5:0] cs [4];
        logic [6:0] es [4];
        xs = '{4'b0001, 4'b0111, 4'b1100, 4'b1000};
        ys = '{4'b0001, 4'b0001, 4'b1010, 4'b1000};
        cs = '{6'b000010, 6'b000010, 6'b000000, 6'b000010};
        es = '{7'b1_0010_0_0, 7'b1_1000_0_1, 7'b1_1000_0_1, 7'b1_0000_1_0};
        for (int i = 0; i < 4; i++) begin
            drive(xs[i], ys[i], cs[i], 1'b1);
            step();
            n_compared++;
            if ({out_valid, out, zr, ng} !== es[i]) begin
                n_mismatched++;
                $display("FAIL b2b_%0d: got %b want %b", i, {out_valid, out, zr, ng}, es[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(4'b0011, 4'b0100, 6'b000010, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_0111_0_0) begin
            n_mismatched++;
            $display("FAIL hold_load: got %b want %b", {out_valid, out, zr, ng}, 7'b1_0111_0_0);
        end
        drive(4'b1111, 4'b1111, 6'b000010, 1'b0);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b0_0111_0_0) begin
            n_mismatched++;
            $display("FAIL hold_idle1: got %b want %b", {out_valid, out, zr, ng}, 7'b0_0111_0_0);
        end
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b0_0111_0_0) begin
            n_mismatched++;
            $display("FAIL hold_idle2: got %b want %b", {out_valid, out, zr, ng}, 7'b0_0111_0_0);
        end
    endtask

    task automatic test_reset_midop();
        drive(4'b0011, 4'b0101, 6'b000010, 1'b1);
        step();
        #2;
        rst = 1'b1;
        #1;
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b0_0000_1_0) begin
            n_mismatched++;
            $display("FAIL midop_async: got %b want %b", {out_valid, out, zr, ng}, 7'b0_0000_1_0);
        end
        step();
        drive(4'b0011, 4'b0101, 6'b000010, 1'b0);
        rst = 1'b0;
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b0_0000_1_0) begin
            n_mismatched++;
            $display("FAIL midop_rel1: got %b want %b", {out_valid, out, zr, ng}, 7'b0_0000_1_0);
        end
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b0_0000_1_0) begin
            n_mismatched++;
            $display("FAIL midop_rel2: got %b want %b", {out_valid, out, zr, ng}, 7'b0_0000_1_0);
        end
        drive(4'b0010, 4'b0011, 6'b000010, 1'b1);
        step();
        n_compared++;
        if ({out_valid, out, zr, ng} !== 7'b1_0101_0_0) begin
            n_mismatched++;
            $display("FAIL midop_first: got %b want %b", {out_valid, out, zr, ng}, 7'b1_0101_0_0);
        end
        drive(4'b0000, 4'b0000, 6'b000000, 1'b0);
        step();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_and();
        test_add();
        test_wrap_const();
        test_back_to_back();
        test_hold();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
